lcd_timing_pattern_gen: RTL and testbench

Parametrised successor to our fixed 480x272 LCD timing generator. It drives an RGB565 parallel LCD and produces HSYNC, VSYNC and DE from fully parametrised porch, sync and active widths, with programmable sync and DE polarity. It also generates active-area pixel coordinates, a start-of-frame strobe, a frame counter and a run-time-selectable test pattern. It sits between the pixel-clock PLL and the LCD pins, and its coordinates also feed downstream frame-buffer readers.

---
 rtl/lcd_timing_pattern_gen_if.sv | 31 +++
 rtl/lcd_timing_pattern_gen.sv | 159 +++++++++++++++
 tb/tb_lcd_timing_pattern_gen.sv | 380 ++++++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/lcd_timing_pattern_gen_if.sv
// Pin-level bundle between the LCD timing generator and its consumers (panel pins, frame-buffer readers).
// master = generator side; slave = consumer / stimulus side.
interface lcd_timing_pattern_gen_if #(
    parameter int CNT_W = 12
);
    logic             EN;
    logic [1:0]       MODE;
    logic [15:0]      SOLID_RGB;
    logic             LCD_HSYNC;
    logic             LCD_VSYNC;
    logic             LCD_DE;
    logic [4:0]       LCD_R;
    logic [5:0]       LCD_G;
    logic [4:0]       LCD_B;
    logic [CNT_W-1:0] PIX_X;
    logic [CNT_W-1:0] PIX_Y;
    logic             SOF;
    logic [7:0]       FRAME_CNT;

    modport master (
        input  EN, MODE, SOLID_RGB,
        output LCD_HSYNC, LCD_VSYNC, LCD_DE, LCD_R, LCD_G, LCD_B,
        output PIX_X, PIX_Y, SOF, FRAME_CNT
    );

    modport slave (
        output EN, MODE, SOLID_RGB,
        input  LCD_HSYNC, LCD_VSYNC, LCD_DE, LCD_R, LCD_G, LCD_B,
        input  PIX_X, PIX_Y, SOF, FRAME_CNT
    );
endinterface

// File: rtl/lcd_timing_pattern_gen.sv
// Parametrised RGB565 LCD timing + test-pattern generator; all outputs registered, 1 cycle behind h/v.
// No backpressure: free-running on PixelClk while EN=1, parked at h=v=0 with idle outputs while EN=0.
module lcd_timing_pattern_gen #(
    parameter int H_SYNC     = 4,
    parameter int H_BP       = 43,
    parameter int H_ACTIVE   = 480,
    parameter int H_FP       = 8,
    parameter int V_SYNC     = 4,
    parameter int V_BP       = 12,
    parameter int V_ACTIVE   = 272,
    parameter int V_FP       = 8,
    parameter int HS_POL     = 0,
    parameter int VS_POL     = 0,
    parameter int DE_POL     = 1,
    parameter int CNT_W      = 12,
    parameter int CHECK_LOG2 = 4
) (
    input  logic PixelClk,
    input  logic RST,
    lcd_timing_pattern_gen_if.master bus
);
    localparam int H_TOTAL = H_SYNC + H_BP + H_ACTIVE + H_FP;
    localparam int V_TOTAL = V_SYNC + V_BP + V_ACTIVE + V_FP;
    localparam int BAR_W   = H_ACTIVE / 8;

    localparam logic HS_ON = (HS_POL != 0);
    localparam logic VS_ON = (VS_POL != 0);
    localparam logic DE_ON = (DE_POL != 0);

    localparam logic [CNT_W-1:0] H_LAST    = CNT_W'(H_TOTAL - 1);
    localparam logic [CNT_W-1:0] V_LAST    = CNT_W'(V_TOTAL - 1);
    localparam logic [CNT_W-1:0] H_SYNC_C  = CNT_W'(H_SYNC);
    localparam logic [CNT_W-1:0] V_SYNC_C  = CNT_W'(V_SYNC);
    localparam logic [CNT_W-1:0] H_START_C = CNT_W'(H_SYNC + H_BP);
    localparam logic [CNT_W-1:0] H_END_C   = CNT_W'(H_SYNC + H_BP + H_ACTIVE);
    localparam logic [CNT_W-1:0] V_START_C = CNT_W'(V_SYNC + V_BP);
    localparam logic [CNT_W-1:0] V_END_C   = CNT_W'(V_SYNC + V_BP + V_ACTIVE);
    localparam logic [CNT_W-1:0] BAR_LAST  = CNT_W'(BAR_W - 1);
    localparam logic [CNT_W-1:0] ONE       = CNT_W'(1);

    logic [CNT_W-1:0] h_cnt, v_cnt, bar_pos;
    logic [3:0]       bar_idx;
    logic [1:0]       mode_q;
    logic [15:0]      solid_q;
    logic [7:0]       frame_q;

    logic             h_act, v_act, de_c, frame_start, line_end, frame_end;
    logic [CNT_W-1:0] x_c, y_c;
    logic [15:0]      x_e, y_e, rgb_c, solid_c;
    logic [1:0]       mode_c;

    always_comb begin
        h_act       = (h_cnt >= H_START_C) && (h_cnt < H_END_C);
        v_act       = (v_cnt >= V_START_C) && (v_cnt < V_END_C);
        de_c        = h_act && v_act;
        frame_start = (h_cnt == '0) && (v_cnt == '0);
        line_end    = (h_cnt == H_LAST);
        frame_end   = line_end && (v_cnt == V_LAST);
        x_c         = de_c ? (h_cnt - H_START_C) : '0;
        y_c         = de_c ? (v_cnt - V_START_C) : '0;
        x_e         = 16'(x_c);
        y_e         = 16'(y_c);
        // The pixel at h=v=0 already belongs to the new frame, so use the live selection there.
        mode_c      = frame_start ? bus.MODE      : mode_q;
        solid_c     = frame_start ? bus.SOLID_RGB : solid_q;
        rgb_c       = 16'h0000;
        if (de_c) begin
            case (mode_c)
                2'd0: rgb_c = solid_c;
                2'd1: begin
                    case (bar_idx)
                        4'd0:    rgb_c = 16'hFFFF;
                        4'd1:    rgb_c = 16'hFFE0;
                        4'd2:    rgb_c = 16'h07FF;
                        4'd3:    rgb_c = 16'h07E0;
                        4'd4:    rgb_c = 16'hF81F;
                        4'd5:    rgb_c = 16'hF800;
                        4'd6:    rgb_c = 16'h001F;
                        default: rgb_c = 16'h0000;
                    endcase
                end
                2'd2: rgb_c = {x_e[8:4], y_e[8:3], x_e[8:4] ^ y_e[8:4]};
                default: rgb_c = (x_e[CHECK_LOG2] ^ y_e[CHECK_LOG2] ^ frame_q[0]) ? 16'hFFFF : 16'h0000;
            endcase
        end
    end

    always_ff @(posedge PixelClk or posedge RST) begin
        if (RST) begin
            h_cnt         <= '0;
            v_cnt         <= '0;
            bar_pos       <= '0;
            bar_idx       <= 4'd0;
            mode_q        <= 2'd0;
            solid_q       <= 16'h0000;
            frame_q       <= 8'd0;
            bus.LCD_HSYNC <= ~HS_ON;
            bus.LCD_VSYNC <= ~VS_ON;
            bus.LCD_DE    <= ~DE_ON;
            bus.LCD_R     <= 5'd0;
            bus.LCD_G     <= 6'd0;
            bus.LCD_B     <= 5'd0;
            bus.PIX_X     <= '0;
            bus.PIX_Y     <= '0;
            bus.SOF       <= 1'b0;
        end else if (!bus.EN) begin
            h_cnt         <= '0;
            v_cnt         <= '0;
            bar_pos       <= '0;
            bar_idx       <= 4'd0;
            bus.LCD_HSYNC <= ~HS_ON;
            bus.LCD_VSYNC <= ~VS_ON;
            bus.LCD_DE    <= ~DE_ON;
            bus.LCD_R     <= 5'd0;
            bus.LCD_G     <= 6'd0;
            bus.LCD_B     <= 5'd0;
            bus.PIX_X     <= '0;
            bus.PIX_Y     <= '0;
            bus.SOF       <= 1'b0;
        end else begin
            h_cnt <= line_end ? '0 : h_cnt + ONE;
            if (line_end) begin
                v_cnt <= (v_cnt == V_LAST) ? '0 : v_cnt + ONE;
            end
            if (frame_end) begin
                frame_q <= frame_q + 8'd1;
            end
            if (frame_start) begin
                mode_q  <= bus.MODE;
                solid_q <= bus.SOLID_RGB;
            end
            // Bar index tracks the current h; index 8 marks the black remainder past the 8th bar.
            if (h_act && !line_end) begin
                if (bar_pos == BAR_LAST) begin
                    bar_pos <= '0;
                    if (bar_idx != 4'd8) begin
                        bar_idx <= bar_idx + 4'd1;
                    end
                end else begin
                    bar_pos <= bar_pos + ONE;
                end
            end else begin
                bar_pos <= '0;
                bar_idx <= 4'd0;
            end
            bus.LCD_HSYNC <= (h_cnt < H_SYNC_C) ? HS_ON : ~HS_ON;
            bus.LCD_VSYNC <= (v_cnt < V_SYNC_C) ? VS_ON : ~VS_ON;
            bus.LCD_DE    <= de_c ? DE_ON : ~DE_ON;
            bus.LCD_R     <= rgb_c[15:11];
            bus.LCD_G     <= rgb_c[10:5];
            bus.LCD_B     <= rgb_c[4:0];
            bus.PIX_X     <= x_c;
            bus.PIX_Y     <= y_c;
            bus.SOF       <= frame_start;
        end
    end

    assign bus.FRAME_CNT = frame_q;
endmodule

// File: tb/tb_lcd_timing_pattern_gen.sv
// Directed bench: small-geometry instance for full-frame behaviour, default-geometry instance for
// the reference DE window and bar colours, wide instance for non-default sync polarity/period.
module tb_lcd_timing_pattern_gen;
    localparam int SH = 27;        // 2+3+20+2
    localparam int SF = SH * 8;    // 8 lines
    localparam int DH = 535;
    localparam int DS = 16 * DH + 47;
    localparam int WH = 1057;

    logic PixelClk = 1'b0;
    logic rst_s = 1'b0, rst_d = 1'b0, rst_w = 1'b0;
    int   cyc = 0;
    int   checks = 0, errors = 0;

    always #5 PixelClk = ~PixelClk;
    always @(posedge PixelClk) cyc <= cyc + 1;

    lcd_timing_pattern_gen_if #(.CNT_W(12)) bs ();
    lcd_timing_pattern_gen_if #(.CNT_W(12)) bd ();
    lcd_timing_pattern_gen_if #(.CNT_W(12)) bw ();

    lcd_timing_pattern_gen #(
        .H_SYNC(2), .H_BP(3), .H_ACTIVE(20), .H_FP(2),
        .V_SYNC(1), .V_BP(2), .V_ACTIVE(4), .V_FP(1), .CHECK_LOG2(2)
    ) u_small (.PixelClk(PixelClk), .RST(rst_s), .bus(bs.master));

    lcd_timing_pattern_gen u_dflt (.PixelClk(PixelClk), .RST(rst_d), .bus(bd.master));

    lcd_timing_pattern_gen #(
        .H_SYNC(1), .H_BP(46), .H_ACTIVE(800), .H_FP(210), .HS_POL(1),
        .V_SYNC(1), .V_BP(1), .V_ACTIVE(2), .V_FP(1)
    ) u_wide (.PixelClk(PixelClk), .RST(rst_w), .bus(bw.master));

    function automatic logic [15:0] bar_col(input int i);
        case (i)
            0: return 16'hFFFF;
            1: return 16'hFFE0;
            2: return 16'h07FF;
            3: return 16'h07E0;
            4: return 16'hF81F;
            5: return 16'hF800;
            6: return 16'h001F;
            default: return 16'h0000;
        endcase
    endfunction

    // Returns #1 after the edge that registers pixel n (pixel 0 = first edge after release at cyc==b).
    task automatic wait_pix(input int b, input int n);
        while (cyc < b + n + 1) begin
            @(posedge PixelClk);
            #1;
        end
    endtask

    task automatic start_s(input logic [1:0] m, input logic [15:0] c, output int b);
        rst_s = 1'b1;
        bs.MODE = m;
        bs.SOLID_RGB = c;
        bs.EN = 1'b1;
        @(negedge PixelClk);
        rst_s = 1'b0;
        b = cyc;
    endtask

    task automatic test_reset();
        logic [51:0] got, exp;
        bs.EN = 1'b1;
        bs.MODE = 2'd3;
        bs.SOLID_RGB = 16'hABCD;
        repeat (3) @(posedge PixelClk);
        #1;
        got = {bs.LCD_HSYNC, bs.LCD_VSYNC, bs.LCD_DE, bs.PIX_X, bs.PIX_Y, bs.SOF,
               bs.LCD_R, bs.LCD_G, bs.LCD_B, bs.FRAME_CNT};
        exp = {1'b1, 1'b1, 1'b0, 12'd0, 12'd0, 1'b0, 16'h0000, 8'd0};
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL reset_values got %h exp %h", got, exp);
        end
        checks++;
        if (bd.LCD_DE !== 1'b0 || bd.LCD_HSYNC !== 1'b1) begin
            errors++;
            $display("FAIL reset_dflt de/hs got %b%b exp 01", bd.LCD_DE, bd.LCD_HSYNC);
        end
        checks++;
        if (bw.LCD_HSYNC !== 1'b0) begin
            errors++;
            $display("FAIL reset_wide_hs got %b exp 0", bw.LCD_HSYNC);
        end
    endtask

    task automatic test_en_low();
        bs.EN = 1'b0;
        @(negedge PixelClk);
        rst_s = 1'b0;
        for (int i = 0; i < 60; i++) begin
            @(posedge PixelClk);
            #1;
            checks++;
            if (bs.LCD_DE !== 1'b0 || bs.SOF !== 1'b0 || bs.LCD_HSYNC !== 1'b1 || bs.FRAME_CNT !== 8'd0) begin
                errors++;
                $display("FAIL en_low cyc=%0d de=%b sof=%b hs=%b fc=%0d exp 0 0 1 0",
                         i, bs.LCD_DE, bs.SOF, bs.LCD_HSYNC, bs.FRAME_CNT);
            end
        end
    endtask

    task automatic test_timing();
        int b, h, v, de_n, sof_n;
        logic e_de;
        logic [51:0] got, exp;
        de_n = 0;
        sof_n = 0;
        start_s(2'd0, 16'h1234, b);
        for (int n = 0; n < 2 * SF; n++) begin
            wait_pix(b, n);
            h = n % SH;
            v = (n / SH) % 8;
            e_de = (h >= 5) && (h < 25) && (v >= 3) && (v < 7);
            exp = {(h >= 2), (v >= 1), e_de, e_de ? 12'(h - 5) : 12'd0, e_de ? 12'(v - 3) : 12'd0,
                   (h == 0 && v == 0), e_de ? 16'h1234 : 16'h0000, 8'((n + 1) / SF)};
            got = {bs.LCD_HSYNC, bs.LCD_VSYNC, bs.LCD_DE, bs.PIX_X, bs.PIX_Y, bs.SOF,
                   bs.LCD_R, bs.LCD_G, bs.LCD_B, bs.FRAME_CNT};
            if (bs.LCD_DE === 1'b1) de_n++;
            if (bs.SOF === 1'b1) sof_n++;
            checks++;
            if (got !== exp) begin
                errors++;
                $display("FAIL timing n=%0d got %h exp %h", n, got, exp);
            end
        end
        checks++;
        if (de_n !== 2 * 80) begin
            errors++;
            $display("FAIL de_count got %0d exp %0d", de_n, 160);
        end
        checks++;
        if (sof_n !== 2) begin
            errors++;
            $display("FAIL sof_count got %0d exp 2", sof_n);
        end
    endtask

    task automatic test_bars();
        int b, h, v, x;
        logic [15:0] e_rgb;
        start_s(2'd1, 16'h0000, b);
        for (int n = 0; n < SF; n++) begin
            wait_pix(b, n);
            h = n % SH;
            v = n / SH;
            x = h - 5;
            e_rgb = 16'h0000;
            if (h >= 5 && h < 25 && v >= 3 && v < 7) e_rgb = (x >= 16) ? 16'h0000 : bar_col(x / 2);
            checks++;
            if ({bs.LCD_R, bs.LCD_G, bs.LCD_B} !== e_rgb) begin
                errors++;
                $display("FAIL bars n=%0d got %h exp %h", n, {bs.LCD_R, bs.LCD_G, bs.LCD_B}, e_rgb);
            end
        end
    endtask

    task automatic test_mode_change();
        int b, h, v, x, y, f;
        logic [15:0] e_rgb;
        start_s(2'd0, 16'hF800, b);
        for (int n = 0; n < 3 * SF; n++) begin
            wait_pix(b, n);
            if (n == 10) bs.MODE = 2'd3;
            h = n % SH;
            v = (n / SH) % 8;
            f = n / SF;
            x = h - 5;
            y = v - 3;
            e_rgb = 16'h0000;
            if (h >= 5 && h < 25 && v >= 3 && v < 7) begin
                if (f == 0) e_rgb = 16'hF800;
                else e_rgb = (x[2] ^ y[2] ^ f[0]) ? 16'hFFFF : 16'h0000;
            end
            checks++;
            if ({bs.LCD_R, bs.LCD_G, bs.LCD_B} !== e_rgb) begin
                errors++;
                $display("FAIL mode_change n=%0d got %h exp %h", n, {bs.LCD_R, bs.LCD_G, bs.LCD_B}, e_rgb);
            end
        end
    endtask

    task automatic test_reset_mid();
        int b;
        start_s(2'd0, 16'h00FF, b);
        wait_pix(b, SF + 5 * SH + 10);
        checks++;
        if (bs.LCD_DE !== 1'b1 || bs.FRAME_CNT !== 8'd1) begin
            errors++;
            $display("FAIL pre_reset de=%b fc=%0d exp 1 1", bs.LCD_DE, bs.FRAME_CNT);
        end
        #2 rst_s = 1'b1;
        #1;
        checks++;
        if ({bs.LCD_DE, bs.LCD_HSYNC, bs.LCD_R, bs.LCD_G, bs.LCD_B, bs.PIX_X, bs.FRAME_CNT} !== {1'b0, 1'b1, 16'h0, 12'd0, 8'd0}) begin
            errors++;
            $display("FAIL async_reset de=%b hs=%b rgb=%h x=%0d fc=%0d exp 0 1 0000 0 0", bs.LCD_DE,
                     bs.LCD_HSYNC, {bs.LCD_R, bs.LCD_G, bs.LCD_B}, bs.PIX_X, bs.FRAME_CNT);
        end
        @(negedge PixelClk);
        rst_s = 1'b0;
        b = cyc;
        wait_pix(b, 0);
        checks++;
        if (bs.SOF !== 1'b1 || bs.LCD_HSYNC !== 1'b0) begin
            errors++;
            $display("FAIL restart_sof sof=%b hs=%b exp 1 0", bs.SOF, bs.LCD_HSYNC);
        end
        wait_pix(b, 1);
        checks++;
        if (bs.SOF !== 1'b0) begin
            errors++;
            $display("FAIL sof_width got %b exp 0", bs.SOF);
        end
        wait_pix(b, 3 * SH + 4);
        checks++;
        if (bs.LCD_DE !== 1'b0) begin
            errors++;
            $display("FAIL restart_pre_de got %b exp 0", bs.LCD_DE);
        end
        wait_pix(b, 3 * SH + 5);
        checks++;
        if (bs.LCD_DE !== 1'b1 || bs.PIX_X !== 12'd0 || bs.PIX_Y !== 12'd0) begin
            errors++;
            $display("FAIL restart_first_de de=%b x=%0d y=%0d exp 1 0 0", bs.LCD_DE, bs.PIX_X, bs.PIX_Y);
        end
    endtask

    task automatic test_en_mid();
        int b;
        start_s(2'd0, 16'h0F0F, b);
        wait_pix(b, 100);
        checks++;
        if (bs.LCD_DE !== 1'b1) begin
            errors++;
            $display("FAIL en_mid_active de got %b exp 1", bs.LCD_DE);
        end
        @(negedge PixelClk);
        bs.EN = 1'b0;
        for (int i = 0; i < 5; i++) begin
            @(posedge PixelClk);
            #1;
            checks++;
            if ({bs.LCD_DE, bs.SOF, bs.LCD_HSYNC, bs.LCD_R, bs.LCD_G, bs.LCD_B, bs.FRAME_CNT} !== {3'b001, 16'h0, 8'd0}) begin
                errors++;
                $display("FAIL en_mid_idle i=%0d de=%b sof=%b hs=%b rgb=%h fc=%0d exp 0 0 1 0000 0", i,
                         bs.LCD_DE, bs.SOF, bs.LCD_HSYNC, {bs.LCD_R, bs.LCD_G, bs.LCD_B}, bs.FRAME_CNT);
            end
        end
        @(negedge PixelClk);
        bs.EN = 1'b1;
        b = cyc;
        wait_pix(b, 0);
        checks++;
        if (bs.SOF !== 1'b1) begin
            errors++;
            $display("FAIL en_restart_sof got %b exp 1", bs.SOF);
        end
        wait_pix(b, SF - 2);
        checks++;
        if (bs.FRAME_CNT !== 8'd0) begin
            errors++;
            $display("FAIL en_frame_cnt_before got %0d exp 0", bs.FRAME_CNT);
        end
        wait_pix(b, SF - 1);
        checks++;
        if (bs.FRAME_CNT !== 8'd1) begin
            errors++;
            $display("FAIL en_frame_cnt_after got %0d exp 1", bs.FRAME_CNT);
        end
    endtask

    task automatic test_default();
        int b;
        int pn [12] = '{0, 3, 4, DH - 1, DH, DS - 1, DS, DS + 59, DS + 60, DS + 419, DS + 420, DS + 479};
        logic [30:0] ex [12];   // {hs, de, x[11:0], rgb[15:0], sof}
        ex[0]  = {1'b0, 1'b0, 12'd0, 16'h0000, 1'b1};
        ex[1]  = {1'b0, 1'b0, 12'd0, 16'h0000, 1'b0};
        ex[2]  = {1'b1, 1'b0, 12'd0, 16'h0000, 1'b0};
        ex[3]  = {1'b1, 1'b0, 12'd0, 16'h0000, 1'b0};
        ex[4]  = {1'b0, 1'b0, 12'd0, 16'h0000, 1'b0};
        ex[5]  = {1'b1, 1'b0, 12'd0, 16'h0000, 1'b0};
        ex[6]  = {1'b1, 1'b1, 12'd0, 16'hFFFF, 1'b0};
        ex[7]  = {1'b1, 1'b1, 12'd59, 16'hFFFF, 1'b0};
        ex[8]  = {1'b1, 1'b1, 12'd60, 16'hFFE0, 1'b0};
        ex[9]  = {1'b1, 1'b1, 12'd419, 16'h001F, 1'b0};
        ex[10] = {1'b1, 1'b1, 12'd420, 16'h0000, 1'b0};
        ex[11] = {1'b1, 1'b1, 12'd479, 16'h0000, 1'b0};
        bd.EN = 1'b1;
        bd.MODE = 2'd1;
        bd.SOLID_RGB = 16'h1111;
        @(negedge PixelClk);
        rst_d = 1'b0;
        b = cyc;
        for (int i = 0; i < 12; i++) begin
            wait_pix(b, pn[i]);
            checks++;
            if ({bd.LCD_HSYNC, bd.LCD_DE, bd.PIX_X, bd.LCD_R, bd.LCD_G, bd.LCD_B, bd.SOF} !== ex[i]) begin
                errors++;
                $display("FAIL dflt_bars n=%0d got %h exp %h", pn[i],
                         {bd.LCD_HSYNC, bd.LCD_DE, bd.PIX_X, bd.LCD_R, bd.LCD_G, bd.LCD_B, bd.SOF}, ex[i]);
            end
        end
        wait_pix(b, DS + 480);
        checks++;
        if (bd.LCD_DE !== 1'b0 || bd.PIX_X !== 12'd0 || {bd.LCD_R, bd.LCD_G, bd.LCD_B} !== 16'h0) begin
            errors++;
            $display("FAIL dflt_de_end de=%b x=%0d exp 0 0", bd.LCD_DE, bd.PIX_X);
        end
        rst_d = 1'b1;
        bd.MODE = 2'd2;
        @(negedge PixelClk);
        rst_d = 1'b0;
        b = cyc;
        wait_pix(b, DS + 479);
        checks++;
        if ({bd.LCD_R, bd.LCD_G, bd.LCD_B} !== 16'hE81D) begin
            errors++;
            $display("FAIL gradient_x479 got %h exp E81D", {bd.LCD_R, bd.LCD_G, bd.LCD_B});
        end
        wait_pix(b, 24 * DH + 47 + 100);
        checks++;
        if ({bd.LCD_R, bd.LCD_G, bd.LCD_B} !== 16'h3026 || bd.PIX_Y !== 12'd8) begin
            errors++;
            $display("FAIL gradient_x100_y8 got %h y=%0d exp 3026 y=8", {bd.LCD_R, bd.LCD_G, bd.LCD_B}, bd.PIX_Y);
        end
        bd.EN = 1'b0;
    endtask

    task automatic test_wide();
        int b, highs;
        highs = 0;
        bw.EN = 1'b1;
        bw.MODE = 2'd0;
        bw.SOLID_RGB = 16'h0000;
        @(negedge PixelClk);
        rst_w = 1'b0;
        b = cyc;
        for (int n = 0; n < 3 * WH; n++) begin
            wait_pix(b, n);
            if (bw.LCD_HSYNC === 1'b1) highs++;
            checks++;
            if (bw.LCD_HSYNC !== ((n % WH) == 0)) begin
                errors++;
                $display("FAIL wide_hs n=%0d got %b exp %b", n, bw.LCD_HSYNC, ((n % WH) == 0));
            end
        end
        checks++;
        if (highs !== 3) begin
            errors++;
            $display("FAIL wide_hs_count got %0d exp 3", highs);
        end
    endtask

    initial begin
        bs.EN = 1'b0; bs.MODE = 2'd0; bs.SOLID_RGB = 16'h0000;
        bd.EN = 1'b0; bd.MODE = 2'd0; bd.SOLID_RGB = 16'h0000;
        bw.EN = 1'b0; bw.MODE = 2'd0; bw.SOLID_RGB = 16'h0000;
        #1;
        rst_s = 1'b1;
        rst_d = 1'b1;
        rst_w = 1'b1;
        test_reset();
        test_en_low();
        test_timing();
        test_bars();
        test_mode_change();
        test_reset_mid();
        test_en_mid();
        test_default();
        test_wide();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
